div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL provide clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide rstn_i, input, 1, synchronous active-low reset, sampled on the rising edge of clk_i.
REQ-003 The block SHALL provide start_i, input, 1, asserted by EX while a valid divide instruction is held in EX.
REQ-004 The block SHALL provide div_oper_i, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 The block SHALL provide operand_a_i, input, 32, the dividend, which is the forwarded rs1 value.
REQ-006 The block SHALL provide operand_b_i, input, 32, the divisor, which is the forwarded rs2 value.
REQ-007 The block SHALL provide flush_i, input, 1, the EX flush that aborts any operation in progress.
REQ-008 The block SHALL provide busy_o, output, 1, high in CALC and DONE.
REQ-009 The block SHALL provide stall_req_o, output, 1, the pipeline stall request to the hazard unit.
REQ-010 The block SHALL provide done_o, output, 1, a one-cycle result-valid strobe.
REQ-011 The block SHALL provide result_o, output, 32, the quotient or remainder, valid only while done_o is high.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE SHALL move to CALC when start_i=1 and flush_i=0, latching the operands, div_oper_i and the sign flags, and clearing a 6-bit iteration counter.
REQ-014 CALC SHALL perform one restoring radix-2 step per cycle on the magnitudes and SHALL move to DONE after exactly 32 steps.
REQ-015 DONE SHALL last exactly one cycle with done_o=1 and SHALL then return to IDLE unconditionally; start_i is not sampled in DONE.
REQ-016 Latency SHALL be as follows: start_i is sampled in IDLE at cycle 0, and done_o and result_o are valid at cycle 33.
REQ-017 stall_req_o SHALL equal start_i AND NOT done_o, combinationally; the pipeline advances in the DONE cycle.
REQ-018 Back-to-back divides SHALL work: a start_i held high in the cycle after DONE starts a new operation from IDLE.
REQ-019 Signed ops SHALL divide absolute values; the quotient is negated iff the operand signs differ, and the remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF for both DIV and DIVU, and remainder = dividend for both REM and REMU.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 flush_i=1 in any state SHALL force IDLE on the next edge with no done_o; this takes priority over start_i and completion.
REQ-023 Operand inputs SHALL be ignored outside the IDLE latch cycle.

Reset
REQ-024 When rstn_i=0 the block SHALL enter IDLE with the counter at 0 and busy_o=0, done_o=0 and result_o=0; stall_req_o still follows REQ-017.
REQ-025 A reset asserted in mid-operation SHALL abandon the operation with no done_o.

Configuration
REQ-026 With macro DIV_FAST_SPECIAL_EN defined, IDLE SHALL go directly to DONE for a zero divisor or signed overflow, so done_o is valid at cycle 1.
REQ-027 Without DIV_FAST_SPECIAL_EN, special cases SHALL take the full 33 cycles; the result values of REQ-020 and REQ-021 apply in both builds.

Verification
REQ-028 DIVU 100/7, start held -> done_o at cycle 33, result 14; stall_req_o high during cycles 0-32 and low at cycle 33.
REQ-029 REM 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
REQ-030 DIV 5/0 -> 0xFFFFFFFF, and REMU 5/0 -> 5, at cycle 1 with DIV_FAST_SPECIAL_EN defined and at cycle 33 without it.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 flush_i pulsed at cycle 10 of a DIVU -> IDLE at cycle 11, no done_o; a new DIVU 9/3 started at cycle 12 -> done_o at cycle 45, result 3.
REQ-033 Two back-to-back DIVU ops (20/4 then 21/4) -> done_o at cycles 33 and 67, results 5 and 5.

Source files
------------

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) for EX,
//            one quotient bit per cycle with pipeline stall handshake.
//            Optional macro DIV_FAST_SPECIAL_EN: zero-divisor and signed
//            overflow cases skip the iteration and complete in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [1:0]  div_oper_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        stall_req_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [5:0]  C_LAST_STEP = 6'd31;
    localparam logic [31:0] C_ALL_ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] C_INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [31:0] rem_q,      rem_d;
    logic [31:0] quo_q,      quo_d;
    logic [31:0] divisor_q,  divisor_d;
    logic [31:0] dividend_q, dividend_d;
    logic        is_rem_q,   is_rem_d;
    logic        a_neg_q,    a_neg_d;
    logic        b_neg_q,    b_neg_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q,      ovf_d;

    logic        w_is_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_ovf;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_result;

    // Operand decode used only in the IDLE latch cycle
    always_comb begin
        w_is_signed = ~div_oper_i[0];
        w_a_neg     = w_is_signed & operand_a_i[31];
        w_b_neg     = w_is_signed & operand_b_i[31];
        w_a_mag     = w_a_neg ? (32'd0 - operand_a_i) : operand_a_i;
        w_b_mag     = w_b_neg ? (32'd0 - operand_b_i) : operand_b_i;
        w_div_zero  = (operand_b_i == 32'd0);
        w_ovf       = w_is_signed & (operand_a_i == C_INT_MIN) & (operand_b_i == C_ALL_ONES);
    end

    // One restoring step: partial remainder always stays below the divisor,
    // so the 32-bit truncated difference is exact whenever it is taken.
    always_comb begin
        w_shift = {rem_q, quo_q[31]};
        w_ge    = (w_shift >= {1'b0, divisor_q});
        w_diff  = w_shift[31:0] - divisor_q;
    end

    // Sign correction and special-case overrides
    always_comb begin
        w_quo_fix = (a_neg_q ^ b_neg_q) ? (32'd0 - quo_q) : quo_q;
        w_rem_fix = a_neg_q ? (32'd0 - rem_q) : rem_q;
        if (div_zero_q) begin
            w_quo_fix = C_ALL_ONES;
            w_rem_fix = dividend_q;
        end else if (ovf_q) begin
            w_quo_fix = C_INT_MIN;
            w_rem_fix = 32'd0;
        end
        w_result = is_rem_q ? w_rem_fix : w_quo_fix;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        is_rem_d   = is_rem_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d      = 6'd0;
                    rem_d      = 32'd0;
                    quo_d      = w_a_mag;
                    divisor_d  = w_b_mag;
                    dividend_d = operand_a_i;
                    is_rem_d   = div_oper_i[1];
                    a_neg_d    = w_a_neg;
                    b_neg_d    = w_b_neg;
                    div_zero_d = w_div_zero;
                    ovf_d      = w_ovf;
`ifdef DIV_FAST_SPECIAL_EN
                    state_d    = (w_div_zero | w_ovf) ? S_DONE : S_CALC;
`else
                    state_d    = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = w_ge ? w_diff : w_shift[31:0];
                quo_d = {quo_q[30:0], w_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == C_LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides both a new start and completion
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            divisor_q  <= 32'd0;
            dividend_q <= 32'd0;
            is_rem_q   <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            is_rem_q   <= is_rem_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        result_o    = done_o ? w_result : 32'd0;
        stall_req_o = start_i & ~done_o;
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed self-checking bench for div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [1:0]  div_oper_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_req_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int L_SPECIAL = 1;
`else
    localparam int L_SPECIAL = 33;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .div_oper_i  (div_oper_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .stall_req_o (stall_req_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: that cycle is cycle 0 of the operation.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit hold);
        int n;
        int stall_low;
        start_i     = 1'b1;
        div_oper_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        chk({tag, "_stall_c0"}, {31'd0, stall_req_o}, 32'd1);
        n = 0;
        stall_low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            n = i;
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            div_oper_i  = 2'($urandom_range(3));
            if (done_o) break;
            if (stall_req_o !== 1'b1) stall_low++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
        chk({tag, "_stall_busy"}, stall_low, 32'd0);
        if (!hold) start_i = 1'b0;
    endtask

    initial begin
        int seen_done;
        rstn_i      = 1'b0;
        start_i     = 1'b0;
        flush_i     = 1'b0;
        div_oper_i  = 2'b00;
        operand_a_i = 32'd0;
        operand_b_i = 32'd0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        start_i = 1'b1;
        #1;
        chk("rst_stall_follows_start", {31'd0, stall_req_o}, 32'd1);
        start_i = 1'b0;
        #1;
        chk("rst_stall_idle", {31'd0, stall_req_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Main function
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        @(negedge clk_i);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        @(negedge clk_i);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        @(negedge clk_i);
        run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        @(negedge clk_i);
        run_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
        @(negedge clk_i);
        run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0);
        @(negedge clk_i);
        run_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
        @(negedge clk_i);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        @(negedge clk_i);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 1'b0);
        @(negedge clk_i);

        // Special cases
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, L_SPECIAL, 1'b0);
        @(negedge clk_i);
        run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, L_SPECIAL, 1'b0);
        @(negedge clk_i);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, L_SPECIAL, 1'b0);
        @(negedge clk_i);
        run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, L_SPECIAL, 1'b0);
        @(negedge clk_i);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, L_SPECIAL, 1'b0);
        @(negedge clk_i);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, L_SPECIAL, 1'b0);
        @(negedge clk_i);

        // Flush at cycle 10, restart at cycle 12
        start_i     = 1'b1;
        div_oper_i  = OP_DIVU;
        operand_a_i = 32'd1000;
        operand_b_i = 32'd3;
        seen_done   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (done_o) seen_done++;
        end
        start_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        if (done_o) seen_done++;
        chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_no_done", seen_done, 32'd0);
        @(negedge clk_i);
        run_op("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);
        @(negedge clk_i);

        // Back-to-back
        run_op("b2b_first", OP_DIVU, 32'd20, 32'd4, 32'd5, 33, 1'b1);
        @(negedge clk_i);
        chk("b2b_idle_busy", {31'd0, busy_o}, 32'd0);
        run_op("b2b_second", OP_DIVU, 32'd21, 32'd4, 32'd5, 33, 1'b0);
        @(negedge clk_i);

        // Reset mid-operation
        start_i     = 1'b1;
        div_oper_i  = OP_DIVU;
        operand_a_i = 32'd77;
        operand_b_i = 32'd5;
        repeat (5) @(negedge clk_i);
        start_i = 1'b0;
        rstn_i  = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) seen_done++;
        end
        chk("midrst_no_done", seen_done, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
